// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline front-end controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    IWAIT = 2'd2
  } state_t;

  // Register $zero never carries a real dependency.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // All-zero word (sll $0,$0,0); IF/ID loads this when flushed.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear.
// Latency: count reflects an inc one clock after it is sampled.
// Backpressure: none; holds at all-ones instead of wrapping, clr wins over inc.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count events, stick at the maximum, clear on request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Front-end sequencing for the 5-stage pipeline: PC/IF-ID enables, flushes, bubbles.
// Latency: control outputs are combinational (same cycle); state/counters update on clk.
// Backpressure: imem wait and load-use stall the PC and IF/ID; branch flush overrides both.
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             idex_mem_read,
  input  logic [4:0]       idex_rt,
  input  logic             branch_taken,
  input  logic             imem_ready,
  input  logic             clear_counters,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  // Remaining wrong-path slots after the branch cycle itself.
  localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);

  state_t     state, next_state;
  logic [1:0] flush_left, next_left;
  logic       load_use;

  // Load in EX writes a register the ID instruction reads.
  assign load_use = idex_mem_read && (idex_rt != REG_ZERO) &&
                    ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

  // State and flush down-counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      flush_left <= 2'd0;
    end else begin
      state      <= next_state;
      flush_left <= next_left;
    end
  end

  // Next state and control outputs; priority branch > imem wait > load-use.
  always_comb begin
    next_state  = state;
    next_left   = flush_left;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (reset) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (branch_taken) begin
      // PC loads the target even if imem is stalled.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        next_state = FLUSH;
        next_left  = FLUSH_RELOAD;
      end else begin
        next_state = imem_ready ? RUN : IWAIT;
        next_left  = 2'd0;
      end
    end else begin
      case (state)
        FLUSH: begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          pc_write    = imem_ready;
          if (imem_ready) begin
            next_left = flush_left - 2'd1;
            if (flush_left == 2'd1) begin
              next_state = RUN;
            end
          end
        end
        default: begin
          // RUN and IWAIT share outputs; IWAIT leaves once imem responds.
          if (!imem_ready) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            next_state  = IWAIT;
          end else begin
            next_state = RUN;
            if (load_use) begin
              pc_write    = 1'b0;
              if_id_write = 1'b0;
              id_ex_flush = 1'b1;
            end
          end
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clear_counters),
    .inc   (!pc_write),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clear_counters),
    .inc   (if_id_flush),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a two-slot branch flush.
// Latency: outputs checked mid-cycle, counters checked after the edge that updates them.
// Backpressure: imem_ready is driven low to exercise the wait state.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [4:0]       ifid_rs = '0;
  logic [4:0]       ifid_rt = '0;
  logic             ifid_uses_rt = 1'b0;
  logic             idex_mem_read = 1'b0;
  logic [4:0]       idex_rt = '0;
  logic             branch_taken = 1'b0;
  logic             imem_ready = 1'b1;
  logic             clear_counters = 1'b0;
  logic             pc_write, if_id_write, if_id_flush, id_ex_flush;
  logic [CNT_W-1:0] stall_count, flush_count;

  int tests = 0;
  int fails = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .ifid_rs        (ifid_rs),
    .ifid_rt        (ifid_rt),
    .ifid_uses_rt   (ifid_uses_rt),
    .idex_mem_read  (idex_mem_read),
    .idex_rt        (idex_rt),
    .branch_taken   (branch_taken),
    .imem_ready     (imem_ready),
    .clear_counters (clear_counters),
    .pc_write       (pc_write),
    .if_id_write    (if_id_write),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .stall_count    (stall_count),
    .flush_count    (flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] rs, rt, ld_rt;
    logic       uses_rt, mem_read;
    logic [3:0] exp;  // {pc_write, if_id_write, if_id_flush, id_ex_flush}
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic chk_ctl(input string name, input logic [3:0] req);
    chk({name, ".ctl"}, int'({pc_write, if_id_write, if_id_flush, id_ex_flush}), int'(req));
  endtask

  task automatic chk_cnt(input string name);
    chk({name, ".stall_count"}, int'(stall_count), exp_stall);
    chk({name, ".flush_count"}, int'(flush_count), exp_flush);
  endtask

  // Let the current cycle's inputs clock in, then return just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifid_rs = 5'd0; ifid_rt = 5'd0; ifid_uses_rt = 1'b0;
    idex_mem_read = 1'b0; idex_rt = 5'd0;
    branch_taken = 1'b0; imem_ready = 1'b1; clear_counters = 1'b0;
  endtask

  initial begin
    vecs[0] = '{"idle",        5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 4'b1100};
    vecs[1] = '{"ld_use_rs",   5'd8, 5'd2, 5'd8, 1'b0, 1'b1, 4'b0001};
    vecs[2] = '{"after_bub",   5'd8, 5'd2, 5'd8, 1'b0, 1'b0, 4'b1100};
    vecs[3] = '{"rt_unused",   5'd4, 5'd9, 5'd9, 1'b0, 1'b1, 4'b1100};
    vecs[4] = '{"rt_zero",     5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 4'b1100};
    vecs[5] = '{"ld_use_rt",   5'd4, 5'd9, 5'd9, 1'b1, 1'b1, 4'b0001};
    vecs[6] = '{"no_load",     5'd9, 5'd9, 5'd9, 1'b1, 1'b0, 4'b1100};

    // Reset: outputs forced, counters zero.
    #3;
    chk_ctl("reset", 4'b0011);
    chk_cnt("reset");
    #9 reset = 1'b0;   // t=12, between edges
    idle_inputs();

    // Single-cycle hazard vectors evaluated in RUN.
    for (int i = 0; i < 7; i++) begin
      ifid_rs = vecs[i].rs; ifid_rt = vecs[i].rt; ifid_uses_rt = vecs[i].uses_rt;
      idex_mem_read = vecs[i].mem_read; idex_rt = vecs[i].ld_rt;
      @(negedge clk);
      chk_ctl(vecs[i].name, vecs[i].exp);
      if (!vecs[i].exp[3]) exp_stall++;
      tick();
    end
    idle_inputs();
    @(negedge clk);
    chk_cnt("table");
    tick();

    // Branch with two flushed slots, then back to RUN.
    branch_taken = 1'b1;
    @(negedge clk); chk_ctl("br_cycle", 4'b1111); tick();
    branch_taken = 1'b0;
    @(negedge clk); chk_ctl("br_flush2", 4'b1111); tick();
    exp_flush += 2;
    @(negedge clk); chk_ctl("br_run", 4'b1100); chk_cnt("br");
    tick();

    // Branch coinciding with load-use: flush only, no stall.
    ifid_rs = 5'd8; idex_mem_read = 1'b1; idex_rt = 5'd8; branch_taken = 1'b1;
    @(negedge clk); chk_ctl("br_lu", 4'b1111); tick();
    branch_taken = 1'b0;
    @(negedge clk); chk_ctl("br_lu_flush2", 4'b1111); tick();
    idle_inputs();
    exp_flush += 2;
    @(negedge clk); chk_cnt("br_lu"); tick();

    // Three imem wait cycles, then resume.
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk_ctl("iwait", 4'b0001); tick();
    end
    imem_ready = 1'b1;
    exp_stall += 3;
    @(negedge clk); chk_ctl("iwait_exit", 4'b1100); chk_cnt("iwait");
    tick();
    @(negedge clk); chk_ctl("iwait_run", 4'b1100); tick();

    // Reset in the middle of a branch flush.
    branch_taken = 1'b1; tick();
    branch_taken = 1'b0;
    #2 reset = 1'b1;
    #1;
    exp_stall = 0; exp_flush = 0;
    chk_ctl("rst_mid_flush", 4'b0011);
    chk_cnt("rst_mid_flush");
    @(negedge clk); #2 reset = 1'b0;
    @(negedge clk); chk_ctl("rst_release", 4'b1100); chk_cnt("rst_release");
    tick();

    // Stall counter saturation, then clear (clear wins over increment).
    imem_ready = 1'b0;
    repeat (65541) @(posedge clk);
    #1;
    chk("sat.stall_count", int'(stall_count), 65535);
    clear_counters = 1'b1;
    tick();
    chk("clr.stall_count", int'(stall_count), 0);
    chk("clr.flush_count", int'(flush_count), 0);
    idle_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, required finish");
    $fatal(1);
  end

endmodule
